// File: rtl/txfifo.sv
// txfifo: byte FIFO between the character generator and the UART transmitter.
// The generator pushes bytes with an active-low write strobe. The transmitter
// pulls them with its native n_cs/n_rd handshake.
//
// Ports:
//   clk      in   system clock, rising edge
//   n_rst    in   asynchronous reset, active low
//   n_wr     in   write strobe, active low, one byte per cycle while low
//   wdata    in   byte to write
//   n_full   out  low while the FIFO holds DEPTH entries
//   n_cs     out  low while the FIFO holds at least one entry
//   data     out  head entry, 8'h00 when empty
//   n_rd     in   low when the transmitter is idle and takes a byte
//   count    out  number of stored entries, 0..DEPTH
//   overflow out  sticky, set by any write attempted while full
module txfifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          n_wr,
  input  logic [7:0]    wdata,
  output logic          n_full,
  output logic          n_cs,
  output logic [7:0]    data,
  input  logic          n_rd,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;

  logic          is_full;
  logic          is_empty;
  logic          push;
  logic          pop;

  // Flags come from the registered count only, so there is no combinational
  // path from n_wr or n_rd to n_cs / n_full.
  assign is_full  = (count_reg == FULL_CNT);
  assign is_empty = (count_reg == '0);

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push = ~n_wr & ~is_full;
  assign pop  = ~is_empty & ~n_rd;

  // Storage has no reset; only the pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (pop) begin
        rp_reg <= rp_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (!n_wr && is_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign n_cs     = is_empty;
  assign n_full   = ~is_full;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  // The transmitter latches data on the pop edge, so the head is read
  // combinationally.
  assign data     = is_empty ? 8'h00 : mem[rp_reg];

endmodule

// File: tb/tb_txfifo.sv
module tb_txfifo;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       n_wr = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic       n_full;
  logic       n_cs;
  logic [7:0] data;
  logic       n_rd = 1'b1;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  txfifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .n_wr     (n_wr),
    .wdata    (wdata),
    .n_full   (n_full),
    .n_cs     (n_cs),
    .data     (data),
    .n_rd     (n_rd),
    .count    (count),
    .overflow (overflow)
  );

  typedef struct {
    logic       n_wr;
    logic [7:0] wdata;
    logic       n_rd;
    logic [4:0] count;
    logic       n_cs;
    logic       n_full;
    logic [7:0] data;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic chk_state(input string nm, input int c, input int cs,
                           input int fl, input int d, input int ov);
    chk({nm, ".count"}, count, c);
    chk({nm, ".n_cs"}, n_cs, cs);
    chk({nm, ".n_full"}, n_full, fl);
    chk({nm, ".data"}, data, d);
    chk({nm, ".overflow"}, overflow, ov);
  endtask

  // Reset pulse of one cycle, asserted and released on falling edges.
  task automatic do_reset();
    n_wr = 1'b1;
    n_rd = 1'b1;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  logic [7:0] q [$];
  logic [7:0] exp_b;
  logic [7:0] msg [5];

  initial begin
    // Single byte, simultaneous push/pop and empty-pop vectors.
    vecs[0] = '{1'b0, 8'h53, 1'b1, 5'd1, 1'b0, 1'b1, 8'h53, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h11, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[3] = '{1'b0, 8'h22, 1'b1, 5'd2, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{1'b0, 8'h33, 1'b1, 5'd3, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[5] = '{1'b0, 8'hAA, 1'b0, 5'd3, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 5'd2, 1'b0, 1'b1, 8'h33, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 8'hAA, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[9] = '{1'b1, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h00, 1'b0};

    // Reset state while held, then after release with no activity.
    @(negedge clk);
    chk_state("reset_held", 0, 1, 1, 0, 0);
    n_rst = 1'b1;
    do_reset();
    @(negedge clk);
    chk_state("reset", 0, 1, 1, 0, 0);

    // Table-driven: drive at a falling edge, check at the next one.
    for (int i = 0; i < 10; i++) begin
      n_wr  = vecs[i].n_wr;
      wdata = vecs[i].wdata;
      n_rd  = vecs[i].n_rd;
      @(negedge clk);
      chk_state($sformatf("vec%0d", i), vecs[i].count, vecs[i].n_cs,
                vecs[i].n_full, vecs[i].data, vecs[i].ovf);
    end
    n_wr = 1'b1;
    n_rd = 1'b1;

    // Burst "Stxyz" while the transmitter is busy, then one pop per frame.
    msg[0] = 8'h53; msg[1] = 8'h74; msg[2] = 8'h78; msg[3] = 8'h79; msg[4] = 8'h7A;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_wr = 1'b0;
      wdata = msg[i];
      @(negedge clk);
    end
    n_wr = 1'b1;
    chk("burst.count", count, 5);
    for (int k = 0; k < 5; k++) begin
      n_rd = 1'b0;
      chk($sformatf("tx%0d.byte", k), data, msg[k]);
      @(negedge clk);
      // Transmitter raises n_rd after accepting and holds it for the frame.
      n_rd = 1'b1;
      chk($sformatf("tx%0d.count", k), count, 4 - k);
      repeat (80) @(negedge clk);
    end
    chk("tx.n_cs_idle", n_cs, 1);

    // Fill with 00..0F, then 10 is dropped and overflow is set.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      n_wr = 1'b0;
      wdata = 8'(i);
      @(negedge clk);
      if (i == 14) chk("fill15.n_full", n_full, 1);
      if (i == 15) begin
        chk("fill16.n_full", n_full, 0);
        chk("fill16.overflow", overflow, 0);
      end
    end
    n_wr = 1'b1;
    chk_state("overfill", 16, 0, 0, 8'h00, 1);
    // Write while full is still dropped when a pop happens on the same edge.
    n_wr = 1'b0;
    wdata = 8'h99;
    n_rd = 1'b0;
    @(negedge clk);
    n_wr = 1'b1;
    chk_state("full_wr_pop", 15, 0, 1, 8'h01, 1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d", i), data, i);
      @(negedge clk);
    end
    n_rd = 1'b1;
    chk_state("drained", 0, 1, 1, 8'h00, 1);

    // 40 bytes through pointer wrap, checked against a queue.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      n_wr = 1'b0;
      wdata = 8'(8'h40 + i);
      n_rd = (i >= 3) ? 1'b0 : 1'b1;
      if (!n_rd) begin
        exp_b = q.pop_front();
        chk($sformatf("wrap%0d", i), data, exp_b);
      end
      q.push_back(wdata);
      @(negedge clk);
    end
    n_wr = 1'b1;
    chk("wrap.count", count, 3);
    n_rd = 1'b0;
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      chk("wrap.tail", data, exp_b);
      @(negedge clk);
    end
    n_rd = 1'b1;
    chk("wrap.empty", n_cs, 1);

    // Mid-operation reset with five entries: effect is immediate.
    for (int i = 0; i < 5; i++) begin
      n_wr = 1'b0;
      wdata = 8'(8'hC0 + i);
      @(negedge clk);
    end
    n_wr = 1'b1;
    chk("pre_rst.count", count, 5);
    #2 n_rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 1, 1, 8'h00, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk_state("post_rst", 0, 1, 1, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/txfifo.md
# txfifo

Byte FIFO sitting directly upstream of the UART transmitter. It absorbs bursts from the character generator and feeds them to the transmitter one at a time using the transmitter's native `n_cs`/`n_rd` handshake. It provides decoupling so that the generator never has to wait on serial line timing, unless the FIFO is full.

## Interface
- `DEPTH`, default 16: number of entries; must be a power of two, 2..256.
- `AW`, default 4: pointer width; must equal log2(DEPTH).

- `clk`  in  1: system clock; all state changes on the rising edge.
- `n_rst`  in  1: asynchronous reset, active low.
- `n_wr`  in  1: write strobe from the producer, active low; one byte per cycle while low.
- `wdata`  in  8: byte to write, sampled when `n_wr` is low.
- `n_full`  out  1: low while the FIFO holds DEPTH entries.
- `n_cs`  out  1: to transmitter `n_cs`; low while the FIFO holds at least one entry.
- `data`  out  8: to transmitter `data`; head entry, 8'h00 when empty.
- `n_rd`  in  1: from transmitter `n_rd`; low means the transmitter is idle and accepts a byte.
- `count`  out  AW+1: number of stored entries, 0..DEPTH.
- `overflow`  out  1: sticky flag, high after any write attempted while full.

## Operation
- Storage is DEPTH×8 register array with write pointer `wp` and read pointer `rp`, both AW bits wide. Pointers wrap modulo DEPTH by natural overflow. `count` is an AW+1 bit register.
- Push event: rising edge with `n_wr`=0 and `count`<DEPTH. It writes `wdata` to `mem[wp]` and increments `wp`.
- Pop event: rising edge with `n_cs`=0 and `n_rd`=0. It increments `rp`. The transmitter latches `data` on this same edge.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Full: a write while `count`==DEPTH is dropped, even if a pop occurs on the same edge. In that case `overflow` is set to 1 and stays 1 until reset.
- Empty: no pop is possible because `n_cs` is high. A push and a pop on the same edge cannot occur when empty.
- `n_cs` = (count==0). `n_full` = ~(count==DEPTH). Both are decoded from registered `count` only, with no combinational path from `n_wr` or `n_rd`.
- `data` = `mem[rp]` when `count`≠0, else 8'h00. It is a combinational read and is stable for as long as `n_cs` stays low without a pop.
- The transmitter raises `n_rd` on the edge after it accepts a byte and holds it high for the full frame. A byte is therefore never popped twice, and `n_cs` may stay low across frames.
- Reset (async, `n_rst`=0): `wp`=0, `rp`=0, `count`=0, `overflow`=0. This gives `n_cs`=1, `n_full`=1, `data`=8'h00. Memory contents are not reset.
- Reset mid-operation discards all entries immediately; the transmitter's in-flight frame is not affected by this block.

## Timing
- Write-to-output latency is 1 cycle. After a push into an empty FIFO, `n_cs` goes low and `data` is valid from the following cycle onward.
- Pop-to-next-data latency is 1 cycle. `data` shows the new head after the pop edge.
- Maximum sustained write rate is 1 byte/clk until full. The read rate is set by the transmitter: one pop per frame.
- `n_full` goes low on the edge that makes `count`==DEPTH. It returns high on the edge of the first pop after that.
- Asserting `n_rst` forces outputs immediately, without waiting for `clk`. Deassertion takes effect at the next rising edge.

## Test plan
- Reset: pulse `n_rst` low for 1 cycle, then release. Require `n_cs`=1, `n_full`=1, `count`=0, `overflow`=0, `data`=00, with no pops and no writes.
- Single byte: hold `n_rd`=1 and write 8'h53 for 1 cycle. Require `n_cs`=0 and `data`=53 one cycle later with `count`=1. Then drive `n_rd`=0 for 1 edge; require `count`=0, `n_cs`=1, `data`=00.
- Ordering with the transmitter: connect the transmitter (CDIV=8) and burst-write "Stxyz" in 5 consecutive cycles. Require the serial line to carry 53,74,78,79,7A in order with one pop per frame, and `count` to fall 5→0.
- Fill and overflow: DEPTH=16, `n_rd`=1, write 17 bytes 00..10. Require `n_full`=0 after the 16th write, byte 10 to be dropped, `overflow`=1, and `count`=16. Draining must return 00..0F.
- Simultaneous push/pop: with `count`=3, write 8'hAA on the same edge as a pop. Require `count`=3, and AA to come out after the two remaining older bytes.
- Wrap and mid-reset: push and pop 40 bytes with ordering checked through pointer wrap. Then assert reset with `count`=5; require `count`=0 and `n_cs`=1 immediately.
